// File: rtl/band_scale_pkg.sv
`default_nettype none
// ============================================================================
// band_scale_pkg : shared widths, unity gain and saturation helper
// rev 1.0
// ============================================================================
package band_scale_pkg;

  localparam int DEF_AUDIO_W   = 16;
  localparam int DEF_GAIN_W    = 13;
  localparam int DEF_FRAC_BITS = 10;
  localparam int UNITY_GAIN    = 1 << DEF_FRAC_BITS;
  localparam int PROD_W        = DEF_AUDIO_W + DEF_GAIN_W;

  typedef struct packed {
    logic ovf;
    logic neg;
  } sat_t;

  // Product arrives sign-extended to 64 bits; it fits the output window only
  // when every bit from the window MSB upward is a copy of the sign.
  function automatic sat_t saturate(input logic signed [63:0] prod,
                                    input int aw, input int fb);
    sat_t               res;
    logic signed [63:0] top_bits;
    top_bits = prod >>> (fb + aw - 1);
    res.ovf  = (top_bits != '0) && (top_bits != '1);
    res.neg  = prod[63];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gain_slew.sv
`default_nettype none
// ============================================================================
// gain_slew : per-band target/current gain registers with bounded slewing
// rev 1.0
// ============================================================================
module gain_slew #(
  parameter int N_BANDS   = 5,
  parameter int BAND_W    = 3,
  parameter int GAIN_W    = 13,
  parameter int FRAC_BITS = 10,
  parameter int RAMP_STEP = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smp_valid,
  input  logic [BAND_W-1:0]        smp_band,
  input  logic                     wr_en,
  input  logic [BAND_W-1:0]        wr_band,
  input  logic [GAIN_W-1:0]        wr_data,
  output logic signed [GAIN_W-1:0] rd_gain
);

  localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1 << FRAC_BITS);
  localparam logic signed [GAIN_W:0]   STEP    = (GAIN_W+1)'(RAMP_STEP);
  localparam logic signed [GAIN_W-1:0] STEP_G  = GAIN_W'(RAMP_STEP);
  localparam bit                       NO_RAMP = (RAMP_STEP == 0);

  logic signed [GAIN_W-1:0] r_cur  [N_BANDS];
  logic signed [GAIN_W-1:0] r_tgt  [N_BANDS];
  logic signed [GAIN_W-1:0] w_next [N_BANDS];
  logic signed [GAIN_W:0]   w_diff [N_BANDS];

  // One extra bit on the difference so the full gain range never wraps.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      w_diff[b] = {r_tgt[b][GAIN_W-1], r_tgt[b]} - {r_cur[b][GAIN_W-1], r_cur[b]};
      if (NO_RAMP || (w_diff[b] <= STEP && w_diff[b] >= -STEP))
        w_next[b] = r_tgt[b];
      else if (!w_diff[b][GAIN_W])
        w_next[b] = r_cur[b] + STEP_G;
      else
        w_next[b] = r_cur[b] - STEP_G;
    end
  end

  // Out-of-range band indices read as gain 0.
  always_comb begin
    rd_gain = '0;
    for (int b = 0; b < N_BANDS; b++)
      if (smp_band == BAND_W'(b)) rd_gain = r_cur[b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++) begin
        r_cur[b] <= UNITY;
        r_tgt[b] <= UNITY;
      end
    end else begin
      for (int b = 0; b < N_BANDS; b++) begin
        if (smp_valid && smp_band == BAND_W'(b)) r_cur[b] <= w_next[b];
        if (wr_en && wr_band == BAND_W'(b))      r_tgt[b] <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/band_scale_pipe.sv
`default_nettype none
// ============================================================================
// band_scale_pipe : 2-stage per-band gain multiply with saturation
// rev 1.0
// ============================================================================
module band_scale_pipe
  import band_scale_pkg::*;
#(
  parameter int AUDIO_W   = DEF_AUDIO_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int N_BANDS   = 5,
  parameter int RAMP_STEP = 256,
  parameter int BAND_W    = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BAND_W-1:0]  in_band,
  input  logic [AUDIO_W-1:0] in_audio,
  input  logic               gain_wr,
  input  logic [BAND_W-1:0]  gain_band,
  input  logic [GAIN_W-1:0]  gain_data,
  input  logic               sat_clr,
  output logic               out_valid,
  output logic [BAND_W-1:0]  out_band,
  output logic [AUDIO_W-1:0] out_scaled,
  output logic [N_BANDS-1:0] sat_flags
);

  localparam int PW = AUDIO_W + GAIN_W;

  logic signed [GAIN_W-1:0] w_gain;
  logic                     r_s1_valid;
  logic [BAND_W-1:0]        r_s1_band;
  logic signed [PW-1:0]     r_s1_prod;
  sat_t                     w_sat;
  logic [AUDIO_W-1:0]       w_sat_val;
  logic [N_BANDS-1:0]       w_set;

  gain_slew #(
    .N_BANDS   (N_BANDS),
    .BAND_W    (BAND_W),
    .GAIN_W    (GAIN_W),
    .FRAC_BITS (FRAC_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_valid (in_valid),
    .smp_band  (in_band),
    .wr_en     (gain_wr),
    .wr_band   (gain_band),
    .wr_data   (gain_data),
    .rd_gain   (w_gain)
  );

  always_comb begin
    w_sat     = saturate(64'(r_s1_prod), AUDIO_W, FRAC_BITS);
    w_sat_val = r_s1_prod[FRAC_BITS+AUDIO_W-1:FRAC_BITS];
    if (w_sat.ovf)
      w_sat_val = w_sat.neg ? {1'b1, {(AUDIO_W-1){1'b0}}} : {1'b0, {(AUDIO_W-1){1'b1}}};
    // A shift past the top bit drops out-of-range bands for free.
    w_set = (r_s1_valid && w_sat.ovf) ? (N_BANDS'(1) << r_s1_band) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_band  <= '0;
      r_s1_prod  <= '0;
      out_valid  <= 1'b0;
      out_band   <= '0;
      out_scaled <= '0;
      sat_flags  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_band <= in_band;
        r_s1_prod <= PW'($signed(in_audio)) * PW'(w_gain);
      end
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_band   <= r_s1_band;
        out_scaled <= w_sat_val;
      end
      sat_flags <= (sat_clr ? '0 : sat_flags) | w_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_band_scale_pipe.sv
`default_nettype none
// ============================================================================
// tb_band_scale_pipe : directed scoreboard bench for band_scale_pipe
// rev 1.0
// ============================================================================
module tb_band_scale_pipe;
  import band_scale_pkg::*;

  localparam int NB   = 5;
  localparam int FB   = 10;
  localparam int STEP = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_band = '0;
  logic [15:0] in_audio = '0;
  logic        gain_wr = 1'b0;
  logic [2:0]  gain_band = '0;
  logic [12:0] gain_data = '0;
  logic        sat_clr = 1'b0;
  logic        out_valid;
  logic [2:0]  out_band;
  logic [15:0] out_scaled;
  logic [4:0]  sat_flags;

  band_scale_pipe #(
    .AUDIO_W(16), .GAIN_W(13), .FRAC_BITS(FB), .N_BANDS(NB), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_band(in_band),
    .in_audio(in_audio), .gain_wr(gain_wr), .gain_band(gain_band),
    .gain_data(gain_data), .sat_clr(sat_clr), .out_valid(out_valid),
    .out_band(out_band), .out_scaled(out_scaled), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  band;
    logic [15:0] val;
    logic        sat;
  } exp_t;

  exp_t        sb[$];
  int          cur_m[NB];
  int          tgt_m[NB];
  logic [4:0]  flags_m;
  logic        s1_v_m;
  logic [2:0]  last_band;
  logic [15:0] last_val;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      cur_m[b] = UNITY_GAIN;
      tgt_m[b] = UNITY_GAIN;
    end
    flags_m = '0; s1_v_m = 1'b0; last_band = '0; last_val = '0;
    sb.delete();
  endtask

  // One clock: drive inputs, update the reference model, check outputs after the edge.
  task automatic cyc(input logic v, input int band, input int audio,
                     input logic wr, input int gb, input int gd, input logic clr);
    exp_t   e;
    longint p, q;
    int     g, d;
    logic   exp_v;
    in_valid = v; in_band = band[2:0]; in_audio = audio[15:0];
    gain_wr = wr; gain_band = gb[2:0]; gain_data = gd[12:0]; sat_clr = clr;
    if (v) begin
      g = (band < NB) ? cur_m[band] : 0;
      p = longint'(audio) * longint'(g);
      q = p >>> FB;
      e.band = band[2:0];
      e.sat  = (q > 32767) || (q < -32768);
      if (q > 32767)       q = 32767;
      else if (q < -32768) q = -32768;
      e.val = q[15:0];
      sb.push_back(e);
      if (band < NB) begin
        d = tgt_m[band] - cur_m[band];
        if (STEP == 0 || (d <= STEP && d >= -STEP)) cur_m[band] = tgt_m[band];
        else cur_m[band] = cur_m[band] + ((d > 0) ? STEP : -STEP);
      end
    end
    if (wr && gb < NB) tgt_m[gb] = gd;
    @(posedge clk);
    #1;
    exp_v  = s1_v_m;
    s1_v_m = v;
    chk("out_valid", out_valid, exp_v);
    if (clr) flags_m = '0;
    if (exp_v) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $error("FAIL scoreboard_underflow: observed=out_valid expected=no_output");
      end else begin
        e = sb.pop_front();
        chk("out_band", out_band, e.band);
        chk("out_scaled", out_scaled, e.val);
        last_band = e.band; last_val = e.val;
        if (e.sat && e.band < NB) flags_m[e.band] = 1'b1;
      end
    end else begin
      chk("hold_band", out_band, last_band);
      chk("hold_scaled", out_scaled, last_val);
    end
    chk("sat_flags", sat_flags, flags_m);
  endtask

  task automatic smp(input int band, input int audio);
    cyc(1'b1, band, audio, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wrg(input int band, input int data);
    cyc(1'b0, 0, 0, 1'b1, band, data, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    model_reset();
    #21;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_band", out_band, 0);
    chk("rst_out_scaled", out_scaled, 0);
    chk("rst_sat_flags", sat_flags, 0);
    rst_n = 1'b1;

    // unity pass-through
    smp(0, 'h1234);
    idle(3);

    // band 1 ramps to near x4 and saturates; clear, then clear colliding with a set
    wrg(1, 4095);
    for (int i = 0; i < 13; i++) smp(1, 'h7000);
    idle(3);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    idle(1);
    smp(1, 'h7000);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    idle(2);

    // out-of-range write ignored, out-of-range sample yields 0 without flags
    wrg(6, 100);
    smp(7, 'h7fff);
    idle(3);

    // band 3: negative full scale with x2 and with x-1
    wrg(3, 2048);
    for (int i = 0; i < 6; i++) smp(3, -32768);
    wrg(3, -1024);
    for (int i = 0; i < 14; i++) smp(3, -32768);
    idle(3);

    // write coinciding with a sample on the same band only affects later slewing
    cyc(1'b1, 4, 'h1000, 1'b1, 4, 0, 1'b0);
    smp(4, 'h1000);
    idle(3);

    // band 2 ramps down to zero
    wrg(2, 0);
    for (int i = 0; i < 6; i++) smp(2, 'h4000);
    idle(3);

    // back-to-back bands 0..4 with distinct gains
    for (int b = 0; b < NB; b++) smp(b, 'h0800 + 'h100 * b);
    smp(0, -'h2000);
    idle(3);

    // reset with samples in flight and band 2 mid-ramp
    wrg(2, 2048);
    smp(2, 'h0100);
    smp(3, 'h0100);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sat_flags", sat_flags, 0);
    #20;
    rst_n = 1'b1;
    model_reset();
    idle(2);
    smp(2, 'h0100);
    idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
